// File: rtl/map_tile_fetcher.sv
// Pixel-side maze tile fetcher: maps screen pixels to tile-map entries, drives the sprite ROM,
// and registers the returned colour. Owns the writable tile map, cleared after every reset.
module map_tile_fetcher #(
  parameter int unsigned MAP_W    = 28,
  parameter int unsigned MAP_H    = 31,
  parameter int unsigned X_OFFSET = 208,
  parameter int unsigned Y_OFFSET = 116
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [9:0]  PIX_X,
  input  logic [9:0]  PIX_Y,
  input  logic        PIX_ACTIVE,
  input  logic        MAP_WE,
  input  logic [9:0]  MAP_ADDR,
  input  logic [6:0]  MAP_WDATA,
  output logic        MAP_READY,
  output logic [4:0]  GRID_SELECT,
  output logic [1:0]  ROTATE_SELECT,
  output logic [2:0]  X_INDEX,
  output logic [2:0]  Y_INDEX,
  input  logic [11:0] MAP_COLOR,
  output logic [11:0] PIXEL_COLOR,
  output logic        PIXEL_VALID
);

  localparam int unsigned Depth = MAP_W * MAP_H;

  typedef enum logic {StInit, StRun} state_e;

  state_e      state;
  logic [9:0]  init_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= StInit;
      init_cnt  <= '0;
      MAP_READY <= 1'b0;
    end else if (state == StInit) begin
      if (init_cnt == 10'(Depth - 1)) begin
        state     <= StRun;
        MAP_READY <= 1'b1;
      end else begin
        init_cnt <= init_cnt + 10'd1;
      end
    end
  end

  // The clear walk owns the write port during INIT; host writes only land in RUN.
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [6:0] wr_data;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = MAP_ADDR;
    wr_data = MAP_WDATA;
    if (!RST) begin
      if (state == StInit) begin
        wr_en   = 1'b1;
        wr_addr = init_cnt;
        wr_data = 7'h00;
      end else begin
        wr_en = MAP_WE && (MAP_ADDR < 10'(Depth));
      end
    end
  end

  logic [6:0] mem [Depth];
  logic [6:0] rd_data;
  logic       rd_en;
  logic [9:0] rd_addr;

  // Read-first: the read samples the array before this edge's write lands.
  always_ff @(posedge CLK) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Unsigned subtraction; bit 10 is the sign of the 11-bit two's-complement offset.
  logic [10:0] dx;
  logic [10:0] dy;
  logic        inmap_c;
  logic [9:0]  addr_c;

  assign dx      = {1'b0, PIX_X} - 11'(X_OFFSET);
  assign dy      = {1'b0, PIX_Y} - 11'(Y_OFFSET);
  assign inmap_c = PIX_ACTIVE && !dx[10] && (dx[9:0] < 10'(8 * MAP_W))
                   && !dy[10] && (dy[9:0] < 10'(8 * MAP_H));
  assign addr_c  = 10'(dy[9:3] * MAP_W + dx[9:3]);

  logic       s0_active;
  logic       s0_inmap;
  logic [9:0] s0_addr;
  logic [2:0] s0_sub_x;
  logic [2:0] s0_sub_y;

  always_ff @(posedge CLK) begin
    if (RST || state != StRun) begin
      s0_active <= 1'b0;
      s0_inmap  <= 1'b0;
      s0_addr   <= '0;
      s0_sub_x  <= '0;
      s0_sub_y  <= '0;
    end else begin
      s0_active <= PIX_ACTIVE;
      s0_inmap  <= inmap_c;
      s0_addr   <= addr_c;
      s0_sub_x  <= dx[2:0];
      s0_sub_y  <= dy[2:0];
    end
  end

  assign rd_en   = s0_inmap;
  assign rd_addr = s0_addr;

  logic s1_active;
  logic s1_inmap;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_active <= 1'b0;
      s1_inmap  <= 1'b0;
      X_INDEX   <= '0;
      Y_INDEX   <= '0;
    end else begin
      s1_active <= s0_active;
      s1_inmap  <= s0_inmap;
      X_INDEX   <= s0_inmap ? s0_sub_x : 3'd0;
      Y_INDEX   <= s0_inmap ? s0_sub_y : 3'd0;
    end
  end

  assign GRID_SELECT   = s1_inmap ? rd_data[6:2] : 5'd0;
  assign ROTATE_SELECT = s1_inmap ? rd_data[1:0] : 2'd0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      PIXEL_COLOR <= 12'h000;
      PIXEL_VALID <= 1'b0;
    end else begin
      PIXEL_COLOR <= s1_inmap ? MAP_COLOR : 12'h000;
      PIXEL_VALID <= s1_active;
    end
  end

endmodule
